// File: rtl/video_hsync_recover.sv
// Recovers horizontal timing from an incoming hsync: measures period and width in
// cend ticks, qualifies the lines and locks a flywheel hcount with a line_start strobe.
module video_hsync_recover #(
   parameter int NOM_PERIOD = 448,
   parameter int PER_TOL    = 4,
   parameter int WID_MIN    = 16,
   parameter int WID_MAX    = 48,
   parameter int LOCK_CNT   = 4,
   parameter int MISS_MAX   = 3,
   parameter int SYNC_POS   = 11,
   parameter int LSTART_POS = 88
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_cend,
   input  logic       i_hsync_in,
   output logic       o_locked,
   output logic [8:0] o_hcount,
   output logic       o_line_start,
   output logic [8:0] o_period,
   output logic [5:0] o_width,
   output logic [7:0] o_err_cnt
);

   localparam logic [8:0] PER_LO    = 9'(NOM_PERIOD - PER_TOL);
   localparam logic [8:0] PER_HI    = 9'(NOM_PERIOD + PER_TOL);
   localparam logic [8:0] PER_TMO   = 9'(NOM_PERIOD + PER_TOL + 1);
   localparam logic [8:0] HC_LAST   = 9'(NOM_PERIOD - 1);
   localparam logic [8:0] HC_SYNC   = 9'(SYNC_POS);
   localparam logic [8:0] HC_LSTART = 9'(LSTART_POS);
   localparam logic [5:0] WID_LO    = 6'(WID_MIN);
   localparam logic [5:0] WID_HI    = 6'(WID_MAX);
   localparam logic [3:0] GOOD_LAST = 4'(LOCK_CNT - 1);
   localparam logic [3:0] MISS_LIM  = 4'(MISS_MAX);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_CHECK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t     r_state, w_state_nxt;
   logic       r_sync1, r_sync2, r_hs_q;
   logic [8:0] r_pcnt, w_pcnt_nxt, w_pcnt_inc;
   logic [5:0] r_wcnt, w_wcnt_nxt, w_wcnt_inc;
   logic [3:0] r_good, w_good_nxt, r_miss, w_miss_nxt;
   logic       r_missed, w_missed_nxt, r_wid_ok, w_wid_ok_nxt;
   logic [8:0] r_hcount, w_hcount_nxt, w_hc_inc;
   logic [8:0] r_period, w_period_nxt;
   logic [5:0] r_width, w_width_nxt;
   logic [7:0] r_err, w_err_nxt;
   logic       r_locked, r_line_start;
   logic       w_rise, w_fall, w_timeout, w_per_good, w_wid_good, w_bad;

   assign w_rise     = i_cend & r_sync2 & ~r_hs_q;
   assign w_fall     = i_cend & ~r_sync2 & r_hs_q;
   assign w_pcnt_inc = (r_pcnt == 9'd511) ? 9'd511 : r_pcnt + 9'd1;
   // The fall tick itself still sees hs_q high, so it is part of the measured width.
   assign w_wcnt_inc = (r_hs_q && (r_wcnt != 6'd63)) ? r_wcnt + 6'd1 : r_wcnt;
   assign w_per_good = (w_pcnt_inc >= PER_LO) && (w_pcnt_inc <= PER_HI);
   assign w_wid_good = (w_wcnt_inc >= WID_LO) && (w_wcnt_inc <= WID_HI);
   assign w_timeout  = i_cend & ~w_rise & (w_pcnt_inc == PER_TMO);
   assign w_hc_inc   = (r_hcount == HC_LAST) ? 9'd0 : r_hcount + 9'd1;

   // Input synchronizer and cend-rate sample of hsync.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_hs_q  <= 1'b0;
      end else begin
         r_sync1 <= i_hsync_in;
         r_sync2 <= r_sync1;
         if (i_cend) r_hs_q <= r_sync2;
      end
   end

   // Measurement, qualification and flywheel next-state logic.
   always_comb begin
      w_state_nxt  = r_state;
      w_pcnt_nxt   = r_pcnt;
      w_wcnt_nxt   = r_wcnt;
      w_good_nxt   = r_good;
      w_miss_nxt   = r_miss;
      w_missed_nxt = r_missed;
      w_wid_ok_nxt = r_wid_ok;
      w_hcount_nxt = r_hcount;
      w_period_nxt = r_period;
      w_width_nxt  = r_width;
      w_err_nxt    = r_err;
      w_bad        = 1'b0;
      if (i_cend) begin
         // A timeout acts as a virtual line edge so a dead input keeps producing misses.
         if (w_rise) begin
            w_pcnt_nxt   = 9'd0;
            w_wcnt_nxt   = 6'd0;
            w_period_nxt = w_pcnt_inc;
         end else if (w_timeout && (r_state != ST_SEARCH)) begin
            w_pcnt_nxt = 9'd0;
            w_wcnt_nxt = w_wcnt_inc;
         end else begin
            w_pcnt_nxt = w_pcnt_inc;
            w_wcnt_nxt = w_wcnt_inc;
         end
         if (w_fall) begin
            w_width_nxt  = w_wcnt_inc;
            w_wid_ok_nxt = w_wid_good;
         end else begin
            w_width_nxt  = r_width;
            w_wid_ok_nxt = r_wid_ok;
         end
         case (r_state)
            ST_SEARCH: begin
               w_hcount_nxt = 9'd0;
               if (w_rise) begin
                  w_state_nxt = ST_CHECK;
                  w_good_nxt  = 4'd0;
               end else begin
                  w_state_nxt = ST_SEARCH;
               end
            end
            ST_CHECK: begin
               w_hcount_nxt = 9'd0;
               if (w_rise) begin
                  if (w_per_good && r_wid_ok) begin
                     if (r_good == GOOD_LAST) begin
                        w_state_nxt  = ST_LOCKED;
                        w_hcount_nxt = HC_SYNC;
                        w_miss_nxt   = 4'd0;
                        w_missed_nxt = 1'b0;
                     end else begin
                        w_good_nxt = r_good + 4'd1;
                     end
                  end else begin
                     w_good_nxt = 4'd0;
                  end
               end else if (w_timeout) begin
                  w_state_nxt = ST_SEARCH;
               end else begin
                  w_state_nxt = ST_CHECK;
               end
            end
            ST_LOCKED: begin
               w_bad        = (w_rise & ~w_per_good) | (w_fall & ~w_wid_good) | w_timeout;
               w_missed_nxt = (w_rise | w_timeout) ? 1'b0 : (r_missed | w_bad);
               if (w_rise && w_per_good && r_wid_ok) begin
                  w_hcount_nxt = HC_SYNC;
                  w_miss_nxt   = 4'd0;
               end else if (w_bad && !r_missed) begin
                  w_miss_nxt = r_miss + 4'd1;
                  w_err_nxt  = (r_err == 8'hFF) ? r_err : r_err + 8'd1;
                  if ((r_miss + 4'd1) >= MISS_LIM) begin
                     w_state_nxt  = ST_SEARCH;
                     w_hcount_nxt = 9'd0;
                  end else begin
                     w_hcount_nxt = w_hc_inc;
                  end
               end else begin
                  w_hcount_nxt = w_hc_inc;
               end
            end
            default: begin
               w_state_nxt  = ST_SEARCH;
               w_hcount_nxt = 9'd0;
            end
         endcase
      end else begin
         w_bad = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_SEARCH;
         r_pcnt       <= 9'd0;
         r_wcnt       <= 6'd0;
         r_good       <= 4'd0;
         r_miss       <= 4'd0;
         r_missed     <= 1'b0;
         r_wid_ok     <= 1'b0;
         r_hcount     <= 9'd0;
         r_period     <= 9'd0;
         r_width      <= 6'd0;
         r_err        <= 8'd0;
         r_locked     <= 1'b0;
         r_line_start <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pcnt       <= w_pcnt_nxt;
         r_wcnt       <= w_wcnt_nxt;
         r_good       <= w_good_nxt;
         r_miss       <= w_miss_nxt;
         r_missed     <= w_missed_nxt;
         r_wid_ok     <= w_wid_ok_nxt;
         r_hcount     <= w_hcount_nxt;
         r_period     <= w_period_nxt;
         r_width      <= w_width_nxt;
         r_err        <= w_err_nxt;
         r_locked     <= (w_state_nxt == ST_LOCKED);
         r_line_start <= i_cend & (w_state_nxt == ST_LOCKED) & (w_hcount_nxt == HC_LSTART);
      end
   end

   assign o_locked     = r_locked;
   assign o_hcount     = r_hcount;
   assign o_line_start = r_line_start;
   assign o_period     = r_period;
   assign o_width      = r_width;
   assign o_err_cnt    = r_err;

endmodule
